slice_serial_subtractor: RTL and testbench

- Multi-cycle subtractor computing `d = a - b` one 4-bit slice per clock, least-significant slice first.
- Each slice uses generate/propagate lookahead on `a` and `~b`, with carry-in 1 for the first slice.
- Sits beside the combinational lookahead adder as its area-lean counterpart, for datapaths that tolerate latency.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/slice_serial_subtractor.sv | 115 +++++++++++
 tb/tb_slice_serial_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_subtractor.sv
// Serial subtractor d = a - b, one 4-bit lookahead slice per clock, LS slice first.
// Latency: WIDTH/4 cycles from accept to out_valid; result held until out_ready.
// Backpressure: no accept outside IDLE; SUB_BACK2BACK_EN lets DONE release and accept on one edge.
module slice_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             borrow,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / 4;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] x_sr, y_sr;
   logic             carry;
   logic [KW-1:0]    k;
   logic             accept, last;
   logic [3:0]       p, g, s;
   logic             c1, c2, c3, c4;

   assign accept = in_valid & in_ready;
   assign last   = (k == LAST_K);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (last) state_nxt = DONE;
         DONE: begin
`ifdef SUB_BACK2BACK_EN
            if (accept)         state_nxt = RUN;
            else if (out_ready) state_nxt = IDLE;
`else
            if (out_ready) state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready is gated by rst so it reads 0 for the whole reset pulse
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = ~rst;
         DONE: begin
            out_valid = 1'b1;
`ifdef SUB_BACK2BACK_EN
            in_ready  = out_ready & ~rst;
`endif
         end
         default: ;
      endcase
   end

   // Lookahead on the current low slice of the shifting operand registers
   always_comb begin
      p  = x_sr[3:0] ^ y_sr[3:0];
      g  = x_sr[3:0] & y_sr[3:0];
      c1 = g[0] | (p[0] & carry);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
      s  = p ^ {c3, c2, c1, carry};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_sr     <= '0;
         y_sr     <= '0;
         carry    <= 1'b0;
         k        <= '0;
         d        <= '0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         x_sr  <= a;
         y_sr  <= ~b;
         carry <= 1'b1;
         k     <= '0;
         d     <= '0;
      end else if (state == RUN) begin
         x_sr       <= x_sr >> 4;
         y_sr       <= y_sr >> 4;
         carry      <= c4;
         k          <= k + 1'b1;
         d[4*k +: 4] <= s;
         if (last) begin
            borrow   <= ~c4;
            overflow <= c3 ^ c4;
         end
      end
   end

endmodule

// File: tb/tb_slice_serial_subtractor.sv
// Directed bench for slice_serial_subtractor (WIDTH=16): vector table plus
// hand sequences for latency, backpressure, async reset and throughput.
module tb_slice_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, d;
   logic        borrow, overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   slice_serial_subtractor #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .borrow(borrow), .overflow(overflow)
   );

   typedef struct {
      logic [15:0] va, vb, exp_d;
      logic        exp_borrow, exp_ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept one pair, measure cycles to out_valid, capture and release the result.
   task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                         output logic [15:0] rd, output logic rb, output logic ro,
                         output int lat);
      int w;
      @(negedge clk);
      a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) check("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = d; rb = borrow; ro = overflow;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] rd, d_hold;
      logic        rb, ro;
      int          lat, rise0, rise1, nrise, exp_period;
      logic        prev_v;

      vecs[0] = '{16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
      vecs[6] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0};
      vecs[7] = '{16'h5555, 16'hAAAA, 16'hAAAB, 1'b1, 1'b1};
      vecs[8] = '{16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_d", d, 0);
      check("rst_borrow_ovf", {borrow, overflow}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].va, vecs[i].vb, rd, rb, ro, lat);
         check($sformatf("v%0d_latency", i), lat, 4);
         check($sformatf("v%0d_d", i), rd, vecs[i].exp_d);
         check($sformatf("v%0d_borrow", i), rb, vecs[i].exp_borrow);
         check($sformatf("v%0d_overflow", i), ro, vecs[i].exp_ovf);
         check($sformatf("v%0d_release", i), out_valid, 0);
      end

      // Backpressure: in_valid stays high with other operands during RUN and DONE
      @(negedge clk);
      a = 16'h1234; b = 16'h0034; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000;
      check("bp_run_in_ready", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("bp_latency", lat, 4);
      d_hold = d;
      check("bp_d", d_hold, 16'h1200);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         check($sformatf("bp_hold_d%0d", i), d, d_hold);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_back_idle", in_ready, 1);
      nrise = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) nrise++;
      end
      check("bp_no_extra_result", nrise, 0);

      // Async reset during slice 2 with a nonzero partial result
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_partial_nonzero", (d != 0), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_d", d, 0);
      check("mid_rst_flags", {out_valid, borrow, overflow, in_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h0010, 16'h0001, rd, rb, ro, lat);
      check("post_rst_d", rd, 16'h000F);
      check("post_rst_latency", lat, 4);

      // Throughput with continuous in_valid and out_ready
`ifdef SUB_BACK2BACK_EN
      exp_period = 5;
`else
      exp_period = 6;
`endif
      @(negedge clk);
      a = 16'h1234; b = 16'h0034; in_valid = 1'b1; out_ready = 1'b1;
      prev_v = 1'b0; nrise = 0; rise0 = 0; rise1 = 0;
      for (int i = 0; i < 40 && nrise < 3; i++) begin
         @(negedge clk);
         if (out_valid && !prev_v) begin
            nrise++;
            check($sformatf("b2b_d%0d", nrise), d, 16'h1200);
            if (nrise == 2) rise0 = cyc;
            if (nrise == 3) rise1 = cyc;
         end
         prev_v = out_valid;
      end
      check("b2b_results", nrise, 3);
      check("b2b_period", rise1 - rise0, exp_period);
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
